// File: rtl/cpu_branch_pkg.sv
// Shared branch-resolution types and constants: branch kinds, condition codes
// and NZCV flag bit positions.
package cpu_branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_UNCOND = 2'd1,
        BR_CBZ    = 2'd2,
        BR_COND   = 2'd3
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// holds for a given NZCV flag vector.
module cond_eval
    import cpu_branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic true_s;

    assign n_s = flags[F_N];
    assign z_s = flags[F_Z];
    assign c_s = flags[F_C];
    assign v_s = flags[F_V];

    // Condition table lookup; both top encodings mean "always".
    always_comb begin
        true_s = 1'b0;
        case (cond)
            COND_EQ: true_s = z_s;
            COND_NE: true_s = ~z_s;
            COND_HS: true_s = c_s;
            COND_LO: true_s = ~c_s;
            COND_MI: true_s = n_s;
            COND_PL: true_s = ~n_s;
            COND_VS: true_s = v_s;
            COND_VC: true_s = ~v_s;
            COND_HI: true_s = c_s & ~z_s;
            COND_LS: true_s = ~c_s | z_s;
            COND_GE: true_s = (n_s == v_s);
            COND_LT: true_s = (n_s != v_s);
            COND_GT: true_s = ~z_s & (n_s == v_s);
            COND_LE: true_s = z_s | (n_s != v_s);
            COND_AL: true_s = 1'b1;
            COND_NV: true_s = 1'b1;
            default: true_s = 1'b0;
        endcase
    end

    assign cond_true = true_s;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: owns the NZCV register, decides branches with same-cycle
// flag bypass, and issues a registered one-cycle redirect/flush pulse.
module branch_resolve
    import cpu_branch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_set_flags,
    input  logic [3:0]        ex_flags,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic              cbz_zero,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_off,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_ifid,
    output logic [3:0]        flags_q,
    output logic [CNT_W-1:0]  taken_cnt
);

    // SHADOW covers the single wrong-path slot right after a redirect.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SHADOW = 1'b1;

    logic [0:0]        state_r;
    logic              redirect_valid_r;
    logic [ADDR_W-1:0] redirect_pc_r;
    logic              flush_ifid_r;
    logic [3:0]        flags_r;
    logic [CNT_W-1:0]  taken_cnt_r;

    logic [3:0]        eff_flags_s;
    logic              cond_true_s;
    logic              accept_s;
    logic              type_hit_s;
    logic              taken_s;
    logic [ADDR_W-1:0] target_s;

    // Bypass the flags the EX instruction is writing this very cycle.
    always_comb begin
        if (ex_set_flags) begin
            eff_flags_s = ex_flags;
        end else begin
            eff_flags_s = flags_r;
        end
    end

    cond_eval u_cond_eval (
        .cond      (br_cond),
        .flags     (eff_flags_s),
        .cond_true (cond_true_s)
    );

    // Per-type taken qualifier; BR_NONE never redirects.
    always_comb begin
        type_hit_s = 1'b0;
        case (br_type)
            BR_NONE:   type_hit_s = 1'b0;
            BR_UNCOND: type_hit_s = 1'b1;
            BR_CBZ:    type_hit_s = cbz_zero;
            BR_COND:   type_hit_s = cond_true_s;
            default:   type_hit_s = 1'b0;
        endcase
    end

    assign accept_s = (state_r == ST_RUN);
    assign taken_s  = br_valid & accept_s & type_hit_s;
    assign target_s = br_pc + br_off;

    // Sequential state: FSM, redirect outputs, flags and taken counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_RUN;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {ADDR_W{1'b0}};
            flush_ifid_r     <= 1'b0;
            flags_r          <= 4'b0000;
            taken_cnt_r      <= {CNT_W{1'b0}};
        end else if (!stall) begin
            // The flag writer is older than any squashed branch, so it always commits.
            if (ex_set_flags) begin
                flags_r <= ex_flags;
            end else begin
                flags_r <= flags_r;
            end
            case (state_r)
                ST_RUN: begin
                    if (taken_s) begin
                        state_r          <= ST_SHADOW;
                        redirect_valid_r <= 1'b1;
                        flush_ifid_r     <= 1'b1;
                        redirect_pc_r    <= target_s;
                        taken_cnt_r      <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r          <= ST_RUN;
                        redirect_valid_r <= 1'b0;
                        flush_ifid_r     <= 1'b0;
                    end
                end
                ST_SHADOW: begin
                    state_r          <= ST_RUN;
                    redirect_valid_r <= 1'b0;
                    flush_ifid_r     <= 1'b0;
                end
                default: begin
                    state_r          <= ST_RUN;
                    redirect_valid_r <= 1'b0;
                    flush_ifid_r     <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush_ifid     = flush_ifid_r;
    assign flags_q        = flags_r;
    assign taken_cnt      = taken_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, multi-cycle
// corner sequences and an exhaustive condition-code sweep.
module tb_branch_resolve;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        ex_set_flags;
    logic [3:0]  ex_flags;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic        cbz_zero;
    logic [63:0] br_pc;
    logic [63:0] br_off;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush_ifid;
    logic [3:0]  flags_q;
    logic [31:0] taken_cnt;

    logic [3:0]  ce_cond;
    logic [3:0]  ce_flags;
    logic        ce_true;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.ADDR_W(64), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .ex_set_flags   (ex_set_flags),
        .ex_flags       (ex_flags),
        .br_valid       (br_valid),
        .br_type        (br_type),
        .br_cond        (br_cond),
        .cbz_zero       (cbz_zero),
        .br_pc          (br_pc),
        .br_off         (br_off),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flags_q        (flags_q),
        .taken_cnt      (taken_cnt)
    );

    cond_eval u_ce (
        .cond      (ce_cond),
        .flags     (ce_flags),
        .cond_true (ce_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  btype;
        logic [3:0]  cond;
        logic        zero;
        logic        setf;
        logic [3:0]  exf;
        logic [63:0] pc;
        logic [63:0] off;
        logic        exp_taken;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_valid = 1'b0; br_type = 2'd0; br_cond = 4'd0; cbz_zero = 1'b0;
        ex_set_flags = 1'b0; ex_flags = 4'd0; br_pc = 64'd0; br_off = 64'd0;
    endtask

    task automatic branch_b(input logic [63:0] pc, input logic [63:0] off);
        br_valid = 1'b1; br_type = 2'd1; br_cond = 4'd0; cbz_zero = 1'b0;
        br_pc = pc; br_off = off;
    endtask

    // Reference built from base-condition pairs: odd codes invert the even one.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, b;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: b = z;
            3'd1: b = c;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = c & !z;
            3'd5: b = (n == v);
            3'd6: b = !z & (n == v);
            default: b = 1'b1;
        endcase
        if (cc[3:1] == 3'd7) return 1'b1;
        return b ^ cc[0];
    endfunction

    logic [3:0]  exp_flags;
    logic [31:0] exp_cnt;

    initial begin
        //              valid type cond   zero setf exf      pc                      off                     taken exp_pc
        vecs[0]  = '{1'b1, 2'd1, 4'h0, 1'b0, 1'b0, 4'h0, 64'h100,                64'h40,                 1'b1, 64'h140};
        vecs[1]  = '{1'b1, 2'd2, 4'h0, 1'b0, 1'b0, 4'h0, 64'h200,                64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0};
        vecs[2]  = '{1'b1, 2'd2, 4'h0, 1'b1, 1'b0, 4'h0, 64'h200,                64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'h1F8};
        vecs[3]  = '{1'b1, 2'd3, 4'h0, 1'b0, 1'b1, 4'h4, 64'h300,                64'h10,                 1'b1, 64'h310};
        vecs[4]  = '{1'b1, 2'd3, 4'h1, 1'b0, 1'b1, 4'h4, 64'h300,                64'h10,                 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 2'd3, 4'h0, 1'b0, 1'b0, 4'h0, 64'h400,                64'h4,                  1'b1, 64'h404};
        vecs[6]  = '{1'b1, 2'd0, 4'hE, 1'b1, 1'b0, 4'h0, 64'h500,                64'h4,                  1'b0, 64'h0};
        vecs[7]  = '{1'b1, 2'd1, 4'h0, 1'b0, 1'b0, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8,                  1'b1, 64'h4};
        vecs[8]  = '{1'b1, 2'd3, 4'hC, 1'b0, 1'b1, 4'h9, 64'h1000,               64'h20,                 1'b1, 64'h1020};
        vecs[9]  = '{1'b1, 2'd3, 4'hB, 1'b0, 1'b0, 4'h0, 64'h1000,               64'h20,                 1'b0, 64'h0};
        vecs[10] = '{1'b1, 2'd3, 4'hE, 1'b0, 1'b0, 4'h0, 64'h0,                  64'h8,                  1'b1, 64'h8};
        vecs[11] = '{1'b0, 2'd1, 4'h0, 1'b0, 1'b0, 4'h0, 64'h800,                64'h8,                  1'b0, 64'h0};

        reset = 1'b1; stall = 1'b0; idle();
        ce_cond = 4'd0; ce_flags = 4'd0;
        step(); step();
        check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_flush", {63'd0, flush_ifid}, 64'd0);
        check("rst_flags", {60'd0, flags_q}, 64'd0);
        check("rst_cnt", {32'd0, taken_cnt}, 64'd0);
        reset = 1'b0;
        exp_flags = 4'd0;
        exp_cnt   = 32'd0;

        // Vector table: each branch is followed by an idle cycle to leave SHADOW.
        for (int i = 0; i < 12; i++) begin
            br_valid = vecs[i].valid; br_type = vecs[i].btype; br_cond = vecs[i].cond;
            cbz_zero = vecs[i].zero; ex_set_flags = vecs[i].setf; ex_flags = vecs[i].exf;
            br_pc = vecs[i].pc; br_off = vecs[i].off;
            if (vecs[i].setf) exp_flags = vecs[i].exf;
            if (vecs[i].exp_taken) exp_cnt = exp_cnt + 32'd1;
            step();
            check($sformatf("v%0d_redirect_valid", i), {63'd0, redirect_valid}, {63'd0, vecs[i].exp_taken});
            check($sformatf("v%0d_flush", i), {63'd0, flush_ifid}, {63'd0, vecs[i].exp_taken});
            if (vecs[i].exp_taken) check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_pc);
            check($sformatf("v%0d_flags", i), {60'd0, flags_q}, {60'd0, exp_flags});
            check($sformatf("v%0d_cnt", i), {32'd0, taken_cnt}, {32'd0, exp_cnt});
            idle();
            step();
            check($sformatf("v%0d_pulse_end", i), {63'd0, redirect_valid | flush_ifid}, 64'd0);
        end

        // Shadow squash: second taken B right behind the first is ignored.
        branch_b(64'h5000, 64'h10);
        step();
        check("sq_first_valid", {63'd0, redirect_valid}, 64'd1);
        check("sq_first_pc", redirect_pc, 64'h5010);
        branch_b(64'h6000, 64'h10);
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("sq_second_valid", {63'd0, redirect_valid}, 64'd0);
        check("sq_pc_hold", redirect_pc, 64'h5010);
        check("sq_cnt", {32'd0, taken_cnt}, {32'd0, exp_cnt});
        idle();
        step();
        check("sq_after_valid", {63'd0, redirect_valid}, 64'd0);

        // Flags written while in SHADOW still commit.
        branch_b(64'h100, 64'h4);
        step();
        exp_cnt = exp_cnt + 32'd1;
        idle();
        ex_set_flags = 1'b1; ex_flags = 4'h3;
        step();
        exp_flags = 4'h3;
        check("shadow_flags", {60'd0, flags_q}, {60'd0, exp_flags});
        idle();
        step();

        // Stall holds the pending redirect, the counter and the flags.
        branch_b(64'h7000, 64'h8);
        step();
        exp_cnt = exp_cnt + 32'd1;
        stall = 1'b1;
        branch_b(64'h9000, 64'h8);
        ex_set_flags = 1'b1; ex_flags = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall%0d_valid", k), {63'd0, redirect_valid}, 64'd1);
            check($sformatf("stall%0d_flush", k), {63'd0, flush_ifid}, 64'd1);
            check($sformatf("stall%0d_pc", k), redirect_pc, 64'h7008);
            check($sformatf("stall%0d_cnt", k), {32'd0, taken_cnt}, {32'd0, exp_cnt});
            check($sformatf("stall%0d_flags", k), {60'd0, flags_q}, {60'd0, exp_flags});
        end
        stall = 1'b0;
        idle();
        step();
        check("stall_release_valid", {63'd0, redirect_valid}, 64'd0);
        check("stall_release_flush", {63'd0, flush_ifid}, 64'd0);
        branch_b(64'hA000, 64'h4);
        step();
        exp_cnt = exp_cnt + 32'd1;
        check("post_stall_run_valid", {63'd0, redirect_valid}, 64'd1);
        check("post_stall_run_pc", redirect_pc, 64'hA004);
        idle();
        step();

        // Reset mid-redirect, overriding a stall and a new taken branch.
        branch_b(64'hB000, 64'h4);
        step();
        check("mid_valid", {63'd0, redirect_valid}, 64'd1);
        reset = 1'b1; stall = 1'b1;
        branch_b(64'hC000, 64'h4);
        ex_set_flags = 1'b1; ex_flags = 4'h8;
        step();
        check("mid_rst_valid", {63'd0, redirect_valid}, 64'd0);
        check("mid_rst_flush", {63'd0, flush_ifid}, 64'd0);
        check("mid_rst_flags", {60'd0, flags_q}, 64'd0);
        check("mid_rst_cnt", {32'd0, taken_cnt}, 64'd0);
        reset = 1'b0; stall = 1'b0;
        branch_b(64'hD000, 64'h10);
        step();
        check("mid_rst_run_valid", {63'd0, redirect_valid}, 64'd1);
        check("mid_rst_run_pc", redirect_pc, 64'hD010);
        check("mid_rst_run_cnt", {32'd0, taken_cnt}, 64'd1);
        idle();
        step();

        // Exhaustive condition sweep on the standalone evaluator.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                ce_cond = 4'(c);
                ce_flags = 4'(f);
                #1;
                check($sformatf("cond_%0h_flags_%0h", c, f), {63'd0, ce_true}, {63'd0, ref_cond(4'(c), 4'(f))});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
